// File: rtl/nn_mlp_seq.sv
// Sequential two-layer MLP (input -> hidden -> output) built around a single
// time-multiplexed multiply-accumulate unit with a valid/ready handshake on each side.
module nn_mlp_seq #(
  parameter int unsigned DW    = 16,
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_HID = 4,
  parameter int unsigned N_OUT = 2,
  parameter int unsigned ACT   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN*DW-1:0]        in_data,
  input  logic [N_IN*N_HID*DW-1:0]  w1,
  input  logic [N_HID*N_OUT*DW-1:0] w2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT*DW-1:0]       out_data,
  output logic                      busy
);

  localparam int unsigned MAX_A = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int unsigned MAX_N = (MAX_A > N_OUT) ? MAX_A : N_OUT;
  localparam int unsigned CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  // Arrays are padded to a power of two so every counter value is a legal index.
  localparam int unsigned CNT   = 1 << CW;

  localparam logic [CW-1:0] IN_LAST  = CW'(N_IN - 1);
  localparam logic [CW-1:0] HID_LAST = CW'(N_HID - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(N_OUT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
  typedef logic [DW-1:0] word_t;

  state_t                state_q, state_d;
  word_t                 x_q [CNT];
  word_t                 x_d [CNT];
  word_t                 h_q [CNT];
  word_t                 h_d [CNT];
  word_t                 x_in [CNT];
  word_t                 w1_a [CNT][CNT];
  word_t                 w2_a [CNT][CNT];
  word_t                 acc_q, acc_d;
  word_t                 mul_a, mul_b, prod, sum;
  logic [CW-1:0]         i_q, i_d, o_q, o_d;
  logic [N_OUT*DW-1:0]   out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  busy_q, busy_d;

  function automatic word_t act_fn(input word_t s);
    return (ACT == 1 && s[DW-1]) ? '0 : s;
  endfunction

  always_comb begin
    x_in = '{default: '0};
    for (int unsigned i = 0; i < N_IN; i++) begin
      x_in[i] = in_data[i*DW +: DW];
    end
  end

  always_comb begin
    w1_a = '{default: '{default: '0}};
    for (int unsigned j = 0; j < N_HID; j++) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        w1_a[j][i] = w1[(j*N_IN + i)*DW +: DW];
      end
    end
  end

  always_comb begin
    w2_a = '{default: '{default: '0}};
    for (int unsigned k = 0; k < N_OUT; k++) begin
      for (int unsigned j = 0; j < N_HID; j++) begin
        w2_a[k][j] = w2[(k*N_HID + j)*DW +: DW];
      end
    end
  end

  // Shared MAC: i_q walks the inner dimension, o_q the neuron being produced.
  always_comb begin
    if (state_q == L2) begin
      mul_a = h_q[i_q];
      mul_b = w2_a[o_q][i_q];
    end else begin
      mul_a = x_q[i_q];
      mul_b = w1_a[o_q][i_q];
    end
    prod = mul_a * mul_b;
    sum  = acc_q + prod;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    h_d         = h_q;
    acc_d       = acc_q;
    i_d         = i_q;
    o_d         = o_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          acc_d   = '0;
          i_d     = '0;
          o_d     = '0;
          state_d = L1;
        end
      end
      L1: begin
        if (i_q == IN_LAST) begin
          h_d[o_q] = act_fn(sum);
          acc_d    = '0;
          i_d      = '0;
          if (o_q == HID_LAST) begin
            o_d     = '0;
            state_d = L2;
          end else begin
            o_d = o_q + ONE;
          end
        end else begin
          acc_d = sum;
          i_d   = i_q + ONE;
        end
      end
      L2: begin
        if (i_q == HID_LAST) begin
          for (int unsigned k = 0; k < N_OUT; k++) begin
            if (o_q == CW'(k)) out_data_d[k*DW +: DW] = sum;
          end
          acc_d = '0;
          i_d   = '0;
          if (o_q == OUT_LAST) begin
            o_d         = '0;
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            o_d = o_q + ONE;
          end
        end else begin
          acc_d = sum;
          i_d   = i_q + ONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d == L1) || (state_d == L2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '{default: '0};
      h_q         <= '{default: '0};
      acc_q       <= '0;
      i_q         <= '0;
      o_q         <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      h_q         <= h_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      o_q         <= o_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_nn_mlp_seq.sv
// Directed bench for nn_mlp_seq: one identity-activation and one ReLU instance
// share stimulus; expected results are hand-computed constants.
module tb_nn_mlp_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [63:0]  in_data;
  logic [255:0] w1;
  logic [127:0] w2;
  logic         in_ready0, out_valid0, busy0;
  logic         in_ready1, out_valid1, busy1;
  logic [31:0]  out_data0, out_data1;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  nn_mlp_seq #(.DW(16), .N_IN(4), .N_HID(4), .N_OUT(2), .ACT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .w1(w1), .w2(w2), .out_valid(out_valid0),
    .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  nn_mlp_seq #(.DW(16), .N_IN(4), .N_HID(4), .N_OUT(2), .ACT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .w1(w1), .w2(w2), .out_valid(out_valid1),
    .out_ready(out_ready), .out_data(out_data1), .busy(busy1)
  );

  // Offers one vector, scrambles in_data after acceptance, counts edges to out_valid.
  task automatic run_vec(input logic [63:0] x, input logic [255:0] wa,
                         input logic [127:0] wb, output int lat);
    @(negedge clk);
    in_data  = x;
    w1       = wa;
    w2       = wb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_CAFE_F00D;
    lat = 0;
    while (out_valid0 !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; w1 = '0; w2 = '0;
    #2;
    checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy0); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
    checks++; if (out_data0 !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 00000000", out_data0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ones();
    int lat;
    run_vec({4{16'd1}}, {16{16'd1}}, {8{16'd1}}, lat);
    checks++; if (lat !== 24) begin errors++; $display("FAIL ones_latency got %0d want 24", lat); end
    checks++; if (out_data0 !== 32'h0010_0010) begin errors++; $display("FAIL ones_y got %h want 00100010", out_data0); end
    checks++; if (busy0 !== 1'b0 || in_ready0 !== 1'b0) begin errors++; $display("FAIL done_flags got busy=%b in_ready=%b want 0 0", busy0, in_ready0); end
    release_out();
  endtask

  task automatic test_ramp();
    int lat;
    run_vec({16'd4, 16'd3, 16'd2, 16'd1}, {16{16'd1}}, {8{16'd2}}, lat);
    checks++; if (lat !== 24) begin errors++; $display("FAIL ramp_latency got %0d want 24", lat); end
    checks++; if (out_data0 !== 32'h0050_0050) begin errors++; $display("FAIL ramp_y got %h want 00500050", out_data0); end
    checks++; if (out_data1 !== 32'h0050_0050) begin errors++; $display("FAIL ramp_y_relu got %h want 00500050", out_data1); end
    release_out();
  endtask

  task automatic test_overflow();
    int lat;
    logic [255:0] wa;
    run_vec({4{16'h0100}}, {16{16'h0100}}, {8{16'd1}}, lat);
    checks++; if (out_data0 !== 32'h0) begin errors++; $display("FAIL ovf_zero_y got %h want 00000000", out_data0); end
    release_out();
    wa = {16{16'h1234}};
    for (int j = 0; j < 4; j++) wa[(j*4)*16 +: 16] = 16'd2;
    run_vec({48'd0, 16'hFFFF}, wa, {8{16'd1}}, lat);
    checks++; if (out_data0 !== 32'hFFF8_FFF8) begin errors++; $display("FAIL ovf_wrap_y got %h want fff8fff8", out_data0); end
    checks++; if (out_data1 !== 32'h0) begin errors++; $display("FAIL ovf_wrap_y_relu got %h want 00000000", out_data1); end
    release_out();
  endtask

  task automatic test_relu();
    int lat;
    logic [255:0] wa;
    wa = {16{16'd1}};
    wa[15:0] = 16'hFFFF;
    run_vec({48'd0, 16'd1}, wa, {8{16'd1}}, lat);
    checks++; if (out_data1 !== 32'h0003_0003) begin errors++; $display("FAIL relu_y got %h want 00030003", out_data1); end
    checks++; if (out_data0 !== 32'h0002_0002) begin errors++; $display("FAIL identity_y got %h want 00020002", out_data0); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_vec({16'd4, 16'd3, 16'd2, 16'd1}, {16{16'd1}}, {8{16'd2}}, lat);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      checks++; if (out_data0 !== 32'h0050_0050) begin errors++; $display("FAIL hold_y c=%0d got %h want 00500050", c, out_data0); end
      checks++; if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin errors++; $display("FAIL hold_flags c=%0d got in_ready=%b out_valid=%b want 0 1", c, in_ready0, out_valid0); end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin errors++; $display("FAIL pop_flags got out_valid=%b in_ready=%b want 0 1", out_valid0, in_ready0); end
    checks++; if (out_data0 !== 32'h0050_0050) begin errors++; $display("FAIL pop_keep_y got %h want 00500050", out_data0); end
    run_vec({4{16'd1}}, {16{16'd1}}, {8{16'd1}}, lat);
    checks++; if (lat !== 24) begin errors++; $display("FAIL b2b_latency got %0d want 24", lat); end
    checks++; if (out_data0 !== 32'h0010_0010) begin errors++; $display("FAIL b2b_y got %h want 00100010", out_data0); end
    release_out();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen;
    @(negedge clk);
    in_data = {4{16'd1}}; w1 = {16{16'd1}}; w2 = {8{16'd1}};
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy0); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b1) begin errors++; $display("FAIL abort_flags got out_valid=%b busy=%b in_ready=%b want 0 0 1", out_valid0, busy0, in_ready0); end
    checks++; if (out_data0 !== 32'h0) begin errors++; $display("FAIL abort_out_data got %h want 00000000", out_data0); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid0 !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_output got %b want 0", seen); end
    run_vec({16'd4, 16'd3, 16'd2, 16'd1}, {16{16'd1}}, {8{16'd2}}, lat);
    checks++; if (lat !== 24) begin errors++; $display("FAIL post_abort_latency got %0d want 24", lat); end
    checks++; if (out_data0 !== 32'h0050_0050) begin errors++; $display("FAIL post_abort_y got %h want 00500050", out_data0); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_ones();
    test_ramp();
    test_overflow();
    test_relu();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
